// File: rtl/edge_pkg.sv
// Shared types and constants for the Sobel front-end window sequencer.
package edge_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int COORD_W = 11;
  localparam int PIX_W   = 8;

  // True when a window centre sits on any edge of a cols x rows frame.
  function automatic logic on_border(
    input logic [COORD_W-1:0] x,
    input logic [COORD_W-1:0] y,
    input int                 cols,
    input int                 rows
  );
    return (x == 11'd0) || (x == COORD_W'(cols - 1)) ||
           (y == 11'd0) || (y == COORD_W'(rows - 1));
  endfunction

endpackage

// File: rtl/linebuf_window_ctrl_if.sv
// Pixel-stream handshake plus line-buffer control and window-status bundle.
interface linebuf_window_ctrl_if;
  import edge_pkg::*;

  logic               pix_valid;
  logic               frame_start;
  logic               pix_ready;
  logic               shift_en;
  logic               flush_active;
  logic               win_valid;
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;
  logic               border;
  logic               frame_done;
  logic               sync_err;

  // Upstream source / downstream observer side.
  modport master (
    output pix_valid, frame_start,
    input  pix_ready, shift_en, flush_active, win_valid, win_x, win_y,
           border, frame_done, sync_err
  );

  // Controller side.
  modport slave (
    input  pix_valid, frame_start,
    output pix_ready, shift_en, flush_active, win_valid, win_x, win_y,
           border, frame_done, sync_err
  );

endinterface

// File: rtl/win_coord_counter.sv
// Tracks the window centre behind the line buffer: a LAG-shift warm-up
// pre-count, then x/y raster counters that wrap at the row end.
module win_coord_counter
  import edge_pkg::*;
#(
  parameter int COLS = 640,
  parameter int ROWS = 480,
  parameter int LAG  = COLS + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               shift,
  input  logic               start,
  output logic               win_valid,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic               border
);

  localparam int                 PRE_W  = $clog2(LAG + 1);
  localparam logic [PRE_W-1:0]   LAG_C  = PRE_W'(LAG);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROWS - 1);

  logic [PRE_W-1:0]   pre_cnt_r, pre_cnt_nxt_s;
  logic               active_r, active_nxt_s;
  logic [COORD_W-1:0] x_r, x_nxt_s;
  logic [COORD_W-1:0] y_r, y_nxt_s;
  logic               emit_s;
  logic               win_valid_r;
  logic [COORD_W-1:0] win_x_r, win_y_r;
  logic               border_r;

  // Next-state of the warm-up counter and the centre raster position.
  always_comb begin
    pre_cnt_nxt_s = pre_cnt_r;
    active_nxt_s  = active_r;
    x_nxt_s       = x_r;
    y_nxt_s       = y_r;
    emit_s        = 1'b0;
    if (shift && start) begin
      // The starting shift is shift number 1 of the new frame.
      pre_cnt_nxt_s = PRE_W'(1);
      active_nxt_s  = 1'b0;
      x_nxt_s       = 11'd0;
      y_nxt_s       = 11'd0;
    end else if (shift && active_r) begin
      emit_s = 1'b1;
      if (x_r == X_LAST) begin
        x_nxt_s = 11'd0;
        if (y_r == Y_LAST) begin
          // Last centre of the frame; stay quiet until the next start.
          y_nxt_s      = 11'd0;
          active_nxt_s = 1'b0;
        end else begin
          y_nxt_s = y_r + 11'd1;
        end
      end else begin
        x_nxt_s = x_r + 11'd1;
      end
    end else if (shift && (pre_cnt_r < LAG_C)) begin
      pre_cnt_nxt_s = pre_cnt_r + PRE_W'(1);
      // After LAG shifts the next shift places pixel 0 at the centre.
      if (pre_cnt_r == (LAG_C - PRE_W'(1))) begin
        active_nxt_s = 1'b1;
      end else begin
        active_nxt_s = active_r;
      end
    end else begin
      pre_cnt_nxt_s = pre_cnt_r;
      active_nxt_s  = active_r;
    end
  end

  // Counter state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_r <= '0;
      active_r  <= 1'b0;
      x_r       <= 11'd0;
      y_r       <= 11'd0;
    end else begin
      pre_cnt_r <= pre_cnt_nxt_s;
      active_r  <= active_nxt_s;
      x_r       <= x_nxt_s;
      y_r       <= y_nxt_s;
    end
  end

  // Registered window strobe; coordinates and border hold between windows.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      win_valid_r <= 1'b0;
      win_x_r     <= 11'd0;
      win_y_r     <= 11'd0;
      border_r    <= 1'b0;
    end else begin
      win_valid_r <= emit_s;
      if (emit_s) begin
        win_x_r  <= x_r;
        win_y_r  <= y_r;
        border_r <= on_border(x_r, y_r, COLS, ROWS);
      end
    end
  end

  assign win_valid = win_valid_r;
  assign win_x     = win_x_r;
  assign win_y     = win_y_r;
  assign border    = border_r;

endmodule

// File: rtl/linebuf_window_ctrl.sv
// Line-buffer sequencer for the 3x3 Sobel window: gates buffer shifts from
// the pixel stream, zero-fills LAG shifts after the last pixel, and reports
// window validity, centre coordinates and frame events.
module linebuf_window_ctrl
  import edge_pkg::*;
#(
  parameter int COLS = 640,
  parameter int ROWS = 480,
  parameter int LAG  = COLS + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  linebuf_window_ctrl_if.slave  bus
);

  localparam int               CNT_W       = $clog2(COLS * ROWS + LAG + 1);
  localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(COLS * ROWS);
  localparam logic [CNT_W-1:0] LAG_CNT_C   = CNT_W'(LAG);

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   in_cnt_r, in_cnt_nxt_s;
  logic [CNT_W-1:0]   flush_cnt_r, flush_cnt_nxt_s;
  logic               ready_s;
  logic               accept_s;
  logic               start_s;
  logic               shift_s;
  logic               flush_s;
  logic               sync_err_nxt_s;
  logic               frame_done_nxt_s;
  logic               sync_err_r;
  logic               frame_done_r;
  logic               win_valid_s;
  logic [COORD_W-1:0] win_x_s;
  logic [COORD_W-1:0] win_y_s;
  logic               border_s;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, counter updates and the combinational buffer controls.
  always_comb begin
    state_nxt_s      = state_r;
    in_cnt_nxt_s     = in_cnt_r;
    flush_cnt_nxt_s  = flush_cnt_r;
    ready_s          = (state_r != FLUSH);
    accept_s         = bus.pix_valid && ready_s &&
                       ((state_r == RUN) || bus.frame_start);
    start_s          = accept_s && bus.frame_start;
    shift_s          = 1'b0;
    flush_s          = 1'b0;
    sync_err_nxt_s   = 1'b0;
    frame_done_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          shift_s         = 1'b1;
          in_cnt_nxt_s    = CNT_W'(1);
          flush_cnt_nxt_s = '0;
          state_nxt_s     = RUN;
        end else if (bus.pix_valid) begin
          // Pixel arriving without a frame start cannot be placed.
          sync_err_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && bus.frame_start) begin
          // Early restart: this pixel becomes pixel 0 of a new frame.
          shift_s        = 1'b1;
          in_cnt_nxt_s   = CNT_W'(1);
          sync_err_nxt_s = 1'b1;
        end else if (accept_s) begin
          shift_s      = 1'b1;
          in_cnt_nxt_s = in_cnt_r + CNT_W'(1);
          if ((in_cnt_r + CNT_W'(1)) == FRAME_PIX_C) begin
            flush_cnt_nxt_s = '0;
            state_nxt_s     = FLUSH;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        shift_s = 1'b1;
        flush_s = 1'b1;
        if (flush_cnt_r == (LAG_CNT_C - CNT_W'(1))) begin
          frame_done_nxt_s = 1'b1;
          flush_cnt_nxt_s  = '0;
          in_cnt_nxt_s     = '0;
          state_nxt_s      = IDLE;
        end else begin
          flush_cnt_nxt_s = flush_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        in_cnt_nxt_s    = '0;
        flush_cnt_nxt_s = '0;
        state_nxt_s     = IDLE;
      end
    endcase
  end

  // Pixel and flush counters plus the registered event pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt_r     <= '0;
      flush_cnt_r  <= '0;
      sync_err_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      in_cnt_r     <= in_cnt_nxt_s;
      flush_cnt_r  <= flush_cnt_nxt_s;
      sync_err_r   <= sync_err_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  win_coord_counter #(
    .COLS (COLS),
    .ROWS (ROWS),
    .LAG  (LAG)
  ) u_coord (
    .clock     (clock),
    .reset_n   (reset_n),
    .shift     (shift_s),
    .start     (start_s),
    .win_valid (win_valid_s),
    .win_x     (win_x_s),
    .win_y     (win_y_s),
    .border    (border_s)
  );

  assign bus.pix_ready    = ready_s;
  assign bus.shift_en     = shift_s;
  assign bus.flush_active = flush_s;
  assign bus.win_valid    = win_valid_s;
  assign bus.win_x        = win_x_s;
  assign bus.win_y        = win_y_s;
  assign bus.border       = border_s;
  assign bus.frame_done   = frame_done_r;
  assign bus.sync_err     = sync_err_r;

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Directed bench for linebuf_window_ctrl with an 8x4 frame (LAG = 9).
module tb_linebuf_window_ctrl;
  import edge_pkg::*;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int LAG  = 9;
  localparam int NPIX = COLS * ROWS;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  linebuf_window_ctrl_if bus ();

  linebuf_window_ctrl #(
    .COLS (COLS),
    .ROWS (ROWS),
    .LAG  (LAG)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Combinational outputs sampled 1 time unit after driving inputs.
  logic c_ready, c_shift, c_flush;
  // Registered outputs sampled at the following falling edge.
  logic r_wv, r_bd, r_fd, r_se;
  logic [10:0] r_wx, r_wy;

  // One clock: drive inputs at a falling edge, sample, advance one cycle.
  task automatic cyc(input logic pv, input logic fs);
    bus.pix_valid   = pv;
    bus.frame_start = fs;
    #1;
    c_ready = bus.pix_ready;
    c_shift = bus.shift_en;
    c_flush = bus.flush_active;
    @(negedge clock);
    r_wv = bus.win_valid;
    r_wx = bus.win_x;
    r_wy = bus.win_y;
    r_bd = bus.border;
    r_fd = bus.frame_done;
    r_se = bus.sync_err;
  endtask

  // Runs one frame from its frame_start pixel and checks every window.
  // mode 0: back-to-back, 1: pix_valid toggles 1,0, 2: pix_valid held high.
  task automatic run_frame(input int mode, input logic exp_se_first, input string tag);
    int   sent, shifts, wins, flushc, cycles;
    logic done, pv, fs, exp_se, exp_bd;
    sent = 0; shifts = 0; wins = 0; flushc = 0; cycles = 0; done = 1'b0;
    while (!done && cycles < 400) begin
      case (mode)
        0:       pv = (sent < NPIX);
        1:       pv = (sent < NPIX) && (cycles % 2 == 0);
        default: pv = 1'b1;
      endcase
      fs = pv && (sent == 0);
      cyc(pv, fs);
      if (c_shift) shifts++;
      if (c_flush) begin
        flushc++;
        total++;
        if (c_ready !== 1'b0 || c_shift !== 1'b1) begin
          bad++;
          $display("FAIL %s flush_gate: ready=%b shift=%b want ready=0 shift=1", tag, c_ready, c_shift);
        end
      end else if (sent < NPIX) begin
        total++;
        if (c_shift !== pv) begin
          bad++;
          $display("FAIL %s shift_gate: shift=%b want %b (cycle %0d)", tag, c_shift, pv, cycles);
        end
      end
      if (pv && c_ready) sent++;
      exp_se = (cycles == 0) ? exp_se_first : 1'b0;
      total++;
      if (r_se !== exp_se) begin
        bad++;
        $display("FAIL %s sync_err: got %b want %b (cycle %0d)", tag, r_se, exp_se, cycles);
      end
      if (r_wv) begin
        exp_bd = (wins % COLS == 0) || (wins % COLS == COLS - 1) ||
                 (wins / COLS == 0) || (wins / COLS == ROWS - 1);
        total++;
        if (r_wx !== 11'(wins % COLS) || r_wy !== 11'(wins / COLS) || r_bd !== exp_bd) begin
          bad++;
          $display("FAIL %s window %0d: got (%0d,%0d) border=%b want (%0d,%0d) border=%b",
                   tag, wins, r_wx, r_wy, r_bd, wins % COLS, wins / COLS, exp_bd);
        end
        if (wins == 0) begin
          total++;
          if (shifts != LAG + 1) begin
            bad++;
            $display("FAIL %s first_window: after shift %0d want after shift %0d", tag, shifts, LAG + 1);
          end
        end
        if (wins == COLS + 1) begin
          total++;
          if (r_bd !== 1'b0) begin
            bad++;
            $display("FAIL %s interior_border: window (1,1) border=%b want 0", tag, r_bd);
          end
        end
        wins++;
      end
      if (r_fd) begin
        done = 1'b1;
        total++;
        if (wins != NPIX || shifts != NPIX + LAG || r_wv !== 1'b1 ||
            r_wx !== 11'd7 || r_wy !== 11'd3) begin
          bad++;
          $display("FAIL %s frame_done: wins=%0d shifts=%0d wv=%b at (%0d,%0d) want wins=%0d shifts=%0d wv=1 at (7,3)",
                   tag, wins, shifts, r_wv, r_wx, r_wy, NPIX, NPIX + LAG);
        end
      end
      cycles++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: frame_done not seen in %0d cycles (wins=%0d)", tag, cycles, wins);
    end
    total++;
    if (flushc != LAG) begin
      bad++;
      $display("FAIL %s flush_len: got %0d flush cycles want %0d", tag, flushc, LAG);
    end
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n         = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    #3;
    total++;
    if ({bus.pix_ready, bus.shift_en, bus.flush_active, bus.win_valid, bus.border,
         bus.frame_done, bus.sync_err} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 1000000", {bus.pix_ready, bus.shift_en,
               bus.flush_active, bus.win_valid, bus.border, bus.frame_done, bus.sync_err});
    end
    total++;
    if (bus.win_x !== 11'd0 || bus.win_y !== 11'd0) begin
      bad++;
      $display("FAIL reset_coords: got (%0d,%0d) want (0,0)", bus.win_x, bus.win_y);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0);
      total++;
      if (c_ready !== 1'b1 || c_shift !== 1'b0 || c_flush !== 1'b0) begin
        bad++;
        $display("FAIL idle_comb: ready=%b shift=%b flush=%b want 1 0 0", c_ready, c_shift, c_flush);
      end
      total++;
      if ({r_wv, r_bd, r_fd, r_se} !== 4'b0000) begin
        bad++;
        $display("FAIL idle_regs: wv/bd/fd/se=%b want 0000", {r_wv, r_bd, r_fd, r_se});
      end
    end
  endtask

  task automatic test_continuous;
    run_frame(0, 1'b0, "continuous");
  endtask

  task automatic test_gapped;
    run_frame(1, 1'b0, "gapped");
  endtask

  task automatic test_resync;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, (i == 0));
      total++;
      if (r_se !== 1'b0) begin
        bad++;
        $display("FAIL resync_pre: sync_err=%b want 0 at pixel %0d", r_se, i);
      end
    end
    run_frame(0, 1'b1, "resync");
  endtask

  task automatic test_stray;
    cyc(1'b1, 1'b0);
    total++;
    if (c_shift !== 1'b0 || r_se !== 1'b1) begin
      bad++;
      $display("FAIL stray_idle: shift=%b sync_err=%b want 0 1", c_shift, r_se);
    end
    cyc(1'b0, 1'b0);
    total++;
    if (r_se !== 1'b0) begin
      bad++;
      $display("FAIL stray_pulse: sync_err=%b want 0", r_se);
    end
    cyc(1'b1, 1'b0);
    total++;
    if (c_shift !== 1'b0 || r_se !== 1'b1) begin
      bad++;
      $display("FAIL stray_still_idle: shift=%b sync_err=%b want 0 1", c_shift, r_se);
    end
    cyc(1'b0, 1'b0);
    run_frame(2, 1'b0, "flush_stray");
  endtask

  task automatic test_reset_flush;
    for (int i = 0; i < NPIX; i++) cyc(1'b1, (i == 0));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      total++;
      if (c_flush !== 1'b1) begin
        bad++;
        $display("FAIL rst_flush_pre: flush_active=%b want 1 (flush cycle %0d)", c_flush, i + 1);
      end
    end
    bus.pix_valid = 1'b0;
    #1;
    total++;
    if (bus.flush_active !== 1'b1) begin
      bad++;
      $display("FAIL rst_flush_4th: flush_active=%b want 1", bus.flush_active);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.pix_ready, bus.shift_en, bus.flush_active, bus.win_valid, bus.border,
         bus.frame_done, bus.sync_err} !== 7'b1000000 ||
        bus.win_x !== 11'd0 || bus.win_y !== 11'd0) begin
      bad++;
      $display("FAIL rst_async: flags=%b coords=(%0d,%0d) want 1000000 (0,0)",
               {bus.pix_ready, bus.shift_en, bus.flush_active, bus.win_valid, bus.border,
                bus.frame_done, bus.sync_err}, bus.win_x, bus.win_y);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b0);
      total++;
      if (r_fd !== 1'b0 || r_wv !== 1'b0 || c_shift !== 1'b0) begin
        bad++;
        $display("FAIL rst_quiet: frame_done=%b win_valid=%b shift=%b want 0 0 0", r_fd, r_wv, c_shift);
      end
    end
    run_frame(0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_resync();
    test_stray();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
